blink_tick_gen: RTL and testbench
=================================

// Module: blink_tick_gen
// PURPOSE
//  Rate generator directly upstream of the LED ring register. Divides the
//  board clock into a 1-cycle tick plus a 50%-duty step_clk that drives the
//  ring's clock/enable input. A debounced push-button cycles through four
//  rates, and a synchronised run switch pauses or resumes stepping.
// PARAMETERS
//  BASE_DIV      6000000  slowest period in clk cycles (rate 0); multiple of 16
//  DEBOUNCE_CYC  120000   cycles speed_btn must be stable to be accepted (>=2)
// PORTS
//  clk        in   1  board clock, all logic on rising edge
//  reset_n    in   1  one clock; reset is asynchronous and active-low
//  run_i      in   1  async level; 1 = stepping enabled
//  speed_btn  in   1  async, active-high, bouncy push-button
//  tick       out  1  1-cycle pulse once per period
//  step_clk   out  1  square wave, period P, rising edge with tick
//  speed_sel  out  2  current rate index 0..3
//  running    out  1  synchronised run_i
// BEHAVIOUR
//  Reset (async assert, sync release): all flops 0.
//   tick=0, step_clk=0, speed_sel=0, running=0, cnt=0, debounce state=0.
//  Sync: run_i and speed_btn each pass through a 2-FF synchroniser.
//   running = second stage of run_i. Input-to-running latency is 2 clk.
//  Debounce: db_cnt counts up while sync_btn != btn_stable and clears
//   when they are equal. When db_cnt == DEBOUNCE_CYC-1 with a mismatch:
//   btn_stable <= sync_btn and db_cnt <= 0.
//   Each 0->1 of btn_stable increments speed_sel mod 4 (3 -> 0), once per press.
//  Period: P = BASE_DIV >> speed_sel (P >= 2, even). cnt width = clog2(BASE_DIV).
//  Counter (priority order, evaluated each clk):
//   1 speed_sel changes this cycle: cnt<=0, tick<=0, step_clk<=0.
//   2 running==0: cnt, step_clk hold; tick<=0. No edges are produced
//     while paused.
//   3 cnt==P-1: cnt<=0, tick<=1, step_clk<=1.
//   4 cnt==P/2-1: cnt<=cnt+1, tick<=0, step_clk<=0.
//   5 otherwise: cnt<=cnt+1, tick<=0.
//  Outputs are registered. tick and the step_clk rise occur in the cycle after cnt==P-1.
//  Steady state: tick every P cycles; step_clk high P/2, low P/2.
//  After a speed change, the next tick comes exactly P_new cycles after the change cycle.
//  On resume, counting continues from the held cnt, so the remaining period is preserved.
//  Async reset mid-operation clears outputs immediately.
//   speed_sel returns to 0 and a press in progress is discarded.
// TESTING (bench params: BASE_DIV=16, DEBOUNCE_CYC=4)
//  1 Reset, then run_i=1 -> running rises 2 clk later.
//    First tick 16 clk after running=1, then every 16 clk.
//    step_clk runs 8 high / 8 low, rising with tick.
//  2 speed_btn pulses of 1-3 clk -> speed_sel stays 0.
//    Clean 6-clk press -> speed_sel=1, ticks every 8 clk.
//    Three more presses -> 2, 3, 0.
//  3 speed_sel=3 -> P=2: tick every 2 clk, step_clk toggles every clk.
//  4 run_i=0 at cnt=5 -> no tick, step_clk and cnt frozen.
//    run_i=1 -> tick 11 clk after running returns to 1.
//  5 Press accepted at cnt=10 (rate 0->1) -> cnt=0, step_clk=0.
//    Next tick exactly 8 clk later.
//  6 reset_n=0 mid-period with speed_sel=2 -> all outputs 0 immediately.
//    After release, ticks resume at P=16.

Source files
------------

// File: rtl/blink_tick_gen.sv
// Rate generator for the LED ring: a 1-cycle tick and a 50%-duty step_clk at one of
// four button-selected rates, paused and resumed by a synchronised run switch.
module blink_tick_gen #(
    parameter int BASE_DIV     = 6000000,
    parameter int DEBOUNCE_CYC = 120000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_i,
    input  logic       speed_btn,
    output logic       tick,
    output logic       step_clk,
    output logic [1:0] speed_sel,
    output logic       running
);

    localparam int CNT_W = $clog2(BASE_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic             r_run_meta;
    logic             r_btn_meta;
    logic             r_btn_sync;
    logic             r_btn_stable;
    logic [DB_W-1:0]  r_db_cnt;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_period;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_half_last;
    logic             w_btn_mismatch;
    logic             w_db_done;
    logic             w_press;

    // NOTE: every flop below uses non-blocking assignment so all registers sample
    // the pre-edge values of their neighbours, exactly like the hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_meta <= 1'b0;
            running    <= 1'b0;
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_run_meta <= run_i;
            running    <= r_run_meta;
            r_btn_meta <= speed_btn;
            r_btn_sync <= r_btn_meta;
        end
    end

    assign w_btn_mismatch = (r_btn_sync != r_btn_stable);
    assign w_db_done      = w_btn_mismatch && (r_db_cnt == DB_LAST);
    assign w_press        = w_db_done && r_btn_sync;

    // A press is accepted only on the rising edge of the debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt     <= '0;
            r_btn_stable <= 1'b0;
            speed_sel    <= 2'd0;
        end else begin
            if (!w_btn_mismatch || w_db_done) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_db_done) begin
                r_btn_stable <= r_btn_sync;
            end
            if (w_press) begin
                speed_sel <= speed_sel + 2'd1;
            end
        end
    end

    assign w_period    = BASE_DIV >> speed_sel;
    assign w_last      = CNT_W'(w_period - 32'd1);
    assign w_half_last = CNT_W'((w_period >> 1) - 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            tick     <= 1'b0;
            step_clk <= 1'b0;
        end else if (w_press) begin
            r_cnt    <= '0;
            tick     <= 1'b0;
            step_clk <= 1'b0;
        end else if (!running) begin
            tick <= 1'b0;
        end else if (r_cnt == w_last) begin
            r_cnt    <= '0;
            tick     <= 1'b1;
            step_clk <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            tick  <= 1'b0;
            if (r_cnt == w_half_last) begin
                step_clk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_tick_gen.sv
// Randomised and directed bench for blink_tick_gen against a cycle-level behavioural
// model that derives step_clk from the position within the current period.
module tb_blink_tick_gen;

    localparam int BASE_DIV = 16;
    localparam int DEB      = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run_i = 1'b0;
    logic       speed_btn = 1'b0;
    logic       tick;
    logic       step_clk;
    logic [1:0] speed_sel;
    logic       running;

    int n_vec = 0;
    int n_err = 0;

    blink_tick_gen #(
        .BASE_DIV    (BASE_DIV),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .run_i    (run_i),
        .speed_btn(speed_btn),
        .tick     (tick),
        .step_clk (step_clk),
        .speed_sel(speed_sel),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit run1, run2, btn1, btn2, stable, tick, primed;
        int mis, sel, cnt;
    } model_t;

    model_t m = '{default: 0};

    // One clock of the reference behaviour: mis = consecutive cycles the synced button
    // disagrees with its accepted level; cnt = running cycles elapsed in this period.
    function automatic model_t model_step(model_t s, bit run, bit btn);
        model_t n;
        int     p;
        bit     acc;
        n   = s;
        p   = BASE_DIV >> s.sel;
        acc = 1'b0;
        if (s.btn2 != s.stable) begin
            n.mis = s.mis + 1;
            if (n.mis == DEB) begin
                n.stable = s.btn2;
                n.mis    = 0;
                acc      = s.btn2;
            end
        end else begin
            n.mis = 0;
        end
        if (acc) begin
            n.sel = (s.sel + 1) % 4;
            n.cnt = 0;
            n.tick = 1'b0;
            n.primed = 1'b0;
        end else if (!s.run2) begin
            n.tick = 1'b0;
        end else if (s.cnt == p - 1) begin
            n.cnt = 0;
            n.tick = 1'b1;
            n.primed = 1'b1;
        end else begin
            n.cnt = s.cnt + 1;
            n.tick = 1'b0;
        end
        n.btn2 = s.btn1;
        n.btn1 = btn;
        n.run2 = s.run1;
        n.run1 = run;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '{default: 0};
        else          m <= model_step(m, run_i, speed_btn);
    end

    // step_clk is high for the first half of every period once a tick has occurred.
    function automatic logic [4:0] model_out();
        int p;
        p = BASE_DIV >> m.sel;
        return {m.tick, (m.primed && (m.cnt < p / 2)), 2'(m.sel), m.run2};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_state: tick/step/sel/run got %b required %b",
                         {tick, step_clk, speed_sel, running}, 5'b0);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_run_start();
        int lat, first, last, highs;
        lat = -1; first = -1; last = -1; highs = 0;
        run_i = 1'b1;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL run_start: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (running === 1'b1) lat = i;
        end
        n_vec++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL run_latency: got %0d required 2", lat);
        end
        for (int i = 1; i <= 40 && first < 0; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL first_period: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (tick === 1'b1) first = i;
        end
        n_vec++;
        if (first !== 16) begin
            n_err++;
            $display("FAIL first_tick_delay: got %0d required 16", first);
        end
        for (int i = 1; i <= 48; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL steady_p16: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (step_clk === 1'b1) highs++;
            if (tick === 1'b1) begin
                n_vec++;
                if (i - last !== 16 && last >= 0 || last < 0 && i !== 16) begin
                    n_err++;
                    $display("FAIL tick_interval_p16: got %0d required 16", last < 0 ? i : i - last);
                end
                last = i;
            end
        end
        n_vec++;
        if (highs !== 24) begin
            n_err++;
            $display("FAIL step_duty_p16: high cycles got %0d required 24", highs);
        end
    endtask

    // Clean 6-cycle press followed by enough idle time for the release to debounce.
    task automatic press(input string tag);
        for (int i = 0; i < 16; i++) begin
            speed_btn = (i < 6);
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL %s: got %b required %b", tag, {tick, step_clk, speed_sel, running}, model_out());
            end
        end
    endtask

    task automatic test_bounce();
        int len, gap;
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 3);
            gap = $urandom_range(5, 9);
            for (int i = 0; i < len + gap; i++) begin
                speed_btn = (i < len);
                @(negedge clk);
                n_vec++;
                if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                    n_err++;
                    $display("FAIL bounce: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
                end
            end
        end
        n_vec++;
        if (speed_sel !== 2'd0) begin
            n_err++;
            $display("FAIL bounce_rejected: speed_sel got %0d required 0", speed_sel);
        end
    endtask

    task automatic test_speed_cycle();
        int last, f;
        press("press_to_1");
        n_vec++;
        if (speed_sel !== 2'd1) begin
            n_err++;
            $display("FAIL speed_sel_1: got %0d required 1", speed_sel);
        end
        last = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL steady_p8: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (i - last !== 8) begin
                        n_err++;
                        $display("FAIL tick_interval_p8: got %0d required 8", i - last);
                    end
                end
                last = i;
            end
        end
        press("press_to_2");
        n_vec++;
        if (speed_sel !== 2'd2) begin
            n_err++;
            $display("FAIL speed_sel_2: got %0d required 2", speed_sel);
        end
        press("press_to_3");
        n_vec++;
        if (speed_sel !== 2'd3) begin
            n_err++;
            $display("FAIL speed_sel_3: got %0d required 3", speed_sel);
        end
        f = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL steady_p2: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (f < 0 && tick === 1'b1) f = i;
            if (f >= 0) begin
                n_vec++;
                if (tick !== logic'((i - f) % 2 == 0) || step_clk !== logic'((i - f) % 2 == 0)) begin
                    n_err++;
                    $display("FAIL p2_toggle: tick/step got %b%b required %b%b", tick, step_clk,
                             logic'((i - f) % 2 == 0), logic'((i - f) % 2 == 0));
                end
            end
        end
        press("press_to_0");
        n_vec++;
        if (speed_sel !== 2'd0) begin
            n_err++;
            $display("FAIL speed_wrap_0: got %0d required 0", speed_sel);
        end
    endtask

    task automatic test_pause();
        int found, back, tk;
        found = 0; back = -1; tk = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL pause_approach: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (m.primed && m.run2 && m.cnt == 3) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL pause_setup: cnt=3 got not reached required reached");
        end
        run_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out() || tick !== 1'b0 || step_clk !== 1'b1) begin
                n_err++;
                $display("FAIL paused: got %b required %b (tick 0, step 1)",
                         {tick, step_clk, speed_sel, running}, model_out());
            end
        end
        run_i = 1'b1;
        for (int i = 1; i <= 30 && tk < 0; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL resume: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (back < 0 && running === 1'b1) back = i;
            if (back >= 0 && tick === 1'b1) tk = i;
        end
        n_vec++;
        if (back < 0 || tk - back !== 11) begin
            n_err++;
            $display("FAIL resume_tick_delay: got %0d required 11", (back < 0 || tk < 0) ? -1 : tk - back);
        end
    endtask

    task automatic test_mid_press();
        int found, chg, tk;
        found = 0; chg = -1; tk = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL midpress_approach: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (m.primed && m.run2 && m.sel == 0 && m.cnt == 5) found = 1;
        end
        speed_btn = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL midpress: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (chg < 0 && speed_sel === 2'd1) begin
                chg = i;
                n_vec++;
                if (step_clk !== 1'b0) begin
                    n_err++;
                    $display("FAIL midpress_step_clear: got %b required 0", step_clk);
                end
            end else if (chg >= 0 && tk < 0 && tick === 1'b1) begin
                tk = i;
            end
            speed_btn = (i < 5);
        end
        n_vec++;
        if (!found || chg !== 5 || tk - chg !== 8) begin
            n_err++;
            $display("FAIL midpress_timing: change/tick got %0d/%0d required 5/8", chg, tk < 0 ? -1 : tk - chg);
        end
    endtask

    task automatic test_reset_mid();
        int back, last;
        back = -1; last = -1;
        press("press_to_2b");
        for (int i = 0; i < 8; i++) begin
            speed_btn = (i >= 5);
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL pre_reset: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
        end
        #2;
        reset_n = 1'b0;
        speed_btn = 1'b0;
        #1;
        n_vec++;
        if ({tick, step_clk, speed_sel, running} !== 5'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b required %b", {tick, step_clk, speed_sel, running}, 5'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL post_reset: got %b required %b", {tick, step_clk, speed_sel, running}, model_out());
            end
            if (back < 0 && running === 1'b1) back = i;
            if (tick === 1'b1) begin
                n_vec++;
                if ((last < 0 && i - back !== 16) || (last >= 0 && i - last !== 16)) begin
                    n_err++;
                    $display("FAIL post_reset_interval: got %0d required 16", last < 0 ? i - back : i - last);
                end
                last = i;
            end
        end
        n_vec++;
        if (last < 0 || speed_sel !== 2'd0) begin
            n_err++;
            $display("FAIL post_reset_rate: sel got %0d ticks %0d required sel 0 with ticks", speed_sel, last);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                speed_btn = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 19) == 0) run_i = ~run_i;
            @(negedge clk);
            n_vec++;
            if ({tick, step_clk, speed_sel, running} !== model_out()) begin
                n_err++;
                $display("FAIL random: cycle %0d got %b required %b", i, {tick, step_clk, speed_sel, running}, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_start();
        test_bounce();
        test_speed_cycle();
        test_pause();
        test_mid_press();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
